// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// One multiplier/quotient bit per cycle; stalls the front end while running.
//
// state | meaning
// IDLE  | waiting for an M-op in EX
// RUN   | shift-add multiply or restoring divide, one bit per cycle
// FIX   | apply signs, select result half, register result
// DONE  | one-cycle done pulse, instruction leaves EX
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2:0]         f3_q;
  logic [4:0]         rd_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic [2*WIDTH-1:0] acc;

  logic               signed_a_in, signed_b_in, neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in, special_res;
  logic               div0, ovf, special, accept;

  assign accept      = (state == IDLE) && start && !flush;
  assign signed_a_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
  assign signed_b_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign neg_a_in    = signed_a_in && op_a[WIDTH-1];
  assign neg_b_in    = signed_b_in && op_b[WIDTH-1];
  assign mag_a_in    = neg_a_in ? -op_a : op_a;
  assign mag_b_in    = neg_b_in ? -op_b : op_b;
  assign div0        = funct3[2] && (op_b == '0);
  assign ovf         = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
  assign special     = div0 || ovf;
  // funct3[1] separates quotient ops (DIV/DIVU) from remainder ops (REM/REMU)
  assign special_res = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MIN_NEG);

  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_step, div_step, acc_step;

  // Multiply: acc = {partial, multiplier}; add into the top, shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
  assign mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, mag_b};
  assign rem_sub  = rem_sh[WIDTH-1:0] - mag_b;
  assign div_step = div_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  assign acc_step = f3_q[2] ? div_step : mul_step;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fix_res;

  assign prod_s = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_s  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_s  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_res = '0;
    case (f3_q)
      3'b000:                 fix_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quo_s;
      default:                fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        stall = start && !flush;
        if (accept) state_nxt = special ? DONE : RUN;
      end
      RUN: begin
        stall = !flush;
        if (flush)          state_nxt = IDLE;
        else if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        stall     = !flush;
        state_nxt = flush ? IDLE : DONE;
      end
      DONE: begin
        done      = !flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      f3_q   <= '0;
      rd_q   <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          f3_q   <= funct3;
          rd_q   <= rd_in;
          sign_a <= neg_a_in;
          sign_b <= neg_b_in;
          mag_a  <= mag_a_in;
          mag_b  <= mag_b_in;
          cnt    <= CW'(WIDTH - 1);
          acc    <= funct3[2] ? {{WIDTH{1'b0}}, mag_a_in} : {{WIDTH{1'b0}}, mag_b_in};
          if (special) begin
            result <= special_res;
            rd_out <= rd_in;
          end
        end
        RUN: if (!flush) begin
          acc <= acc_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: if (!flush) begin
          result <= fix_res;
          rd_out <= rd_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected results queued at launch,
// compared when done pulses; stall/busy/reset/flush checked inline.
module tb_ex_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b;
  logic [4:0]   rd_in;
  logic         stall, busy, done;
  logic [W-1:0] result;
  logic [4:0]   rd_out;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall(stall), .busy(busy),
    .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    int           cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("rd_out", 64'(rd_out), 64'(e.rd));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic logic [W-1:0] mref(input logic [2:0] f3, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return LAT;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] exp, input bit push);
    exp_t e;
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    if (push) begin
      e.res = exp; e.rd = rd; e.cyc = cyc + lat_of(f3, a, b);
      sb_q.push_back(e);
    end
  endtask

  // Launches one op, checks stall over its whole latency, single-cycle done and hold.
  task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] exp);
    int lat;
    lat = lat_of(f3, a, b);
    step();
    launch(f3, a, b, rd, exp, 1'b1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("stall_active", 64'(stall), 64'd1);
      step();
      start = 1'b0;
    end
    @(negedge clk);
    chk("stall_done", 64'(stall), 64'd0);
    chk("busy_done", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("result_hold", 64'(result), 64'(exp));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    step(); step();
    @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_rd_out", 64'(rd_out), 64'd0);
    rst = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 32'd2);
    run_op(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5, 32'd0, 5'd14, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);

    // Flush a DIV at cycle 10, then start a MUL at cycle 11.
    step();
    launch(3'd4, 32'd1000, 32'd3, 5'd20, 32'd0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    step();
    flush = 1'b0;
    launch(3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 1'b1);
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      start = 1'b0;
    end

    // start held through DONE; second op launched at cycle 35.
    step();
    launch(3'd5, 32'd100, 32'd7, 5'd22, 32'd14, 1'b1);
    for (int i = 1; i <= LAT; i++) step();
    @(negedge clk);
    chk("hold_done", 64'(done), 64'd1);
    step();
    launch(3'd3, 32'hFFFF_FFFF, 32'd3, 5'd23, 32'd2, 1'b1);
    @(negedge clk);
    chk("hold_relaunch_busy", 64'(busy), 64'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      start = 1'b0;
    end

    // Reset asserted at cycle 20 of a MUL.
    step();
    launch(3'd0, 32'd9, 32'd9, 5'd24, 32'd0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_rd_out", 64'(rd_out), 64'd0);
    for (int i = 0; i < LAT + 4; i++) step();

    for (int k = 0; k < 10; k++) begin
      logic [2:0] f3;
      logic [W-1:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = (k % 3 == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      b  = (k % 4 == 1) ? 32'd0 : ((k % 3 == 1) ? 32'($urandom_range(1, 9)) : $urandom);
      run_op(f3, a, b, 5'(k + 1), mref(f3, a, b));
    end

    step(); step();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multi-cycle multiply/divide sequencer for the RV32M instructions, sitting beside the execute-stage ALU. It accepts forwarded operands from EX and freezes the front of the pipeline while it runs. It iterates one bit per cycle and returns a single-cycle `done` pulse with the result and destination register. The hazard unit ORs `stall` into its IF/ID/ID-EX hold logic. The WB-select mux takes `result` instead of `alu_result` when `done`=1.

## Interface
Parameters:
- `WIDTH`, default 32 (package value): operand/result width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the clock edge).
- `start`  in  1  EX holds an M-op (opcode 0110011, funct7 0000001). Decoded upstream.
- `flush`  in  1  EX instruction is being squashed (branch taken).
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  WIDTH  forwarded rs1 value (post fwd_a mux).
- `op_b`  in  WIDTH  forwarded rs2 value (post fwd_b mux, never imm).
- `rd_in`  in  5  destination register.
- `stall`  out  1  hold IF, ID, and ID/EX this cycle.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse: `result`/`rd_out` valid.
- `result`  out  WIDTH  product/quotient/remainder.
- `rd_out`  out  5  latched `rd_in`.

## Operation
- States: IDLE, RUN, FIX, DONE. Registered: state, 5-bit-wide counter (log2 WIDTH), latched funct3/rd, magnitudes |a|,|b|, sign flags, 2·WIDTH accumulator.
- IDLE, `start`=1: latch operands and compute magnitudes.
  - Signed: MULH both signed; MULHSU a only; DIV/REM both.
  - Unsigned: MULHU, DIVU, REMU.
  - Load counter = WIDTH-1, then go to RUN.
  - Special cases skip RUN and go straight to DONE:
    - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give `op_a`.
    - Signed overflow (op_a = 0x80…0, op_b = all-ones): DIV gives 0x80…0; REM gives 0.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 2·WIDTH product.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle; partial remainder kept.
- RUN: when the counter reaches 0, go to FIX. Otherwise decrement.
- FIX: apply signs.
  - Product: negated if sign_a XOR sign_b.
  - Quotient: negated if sign_a XOR sign_b.
  - Remainder: takes sign_a.
- FIX result select: MUL gives product[WIDTH-1:0]; MULH* gives product[2W-1:W]. Register `result`, then go to DONE.
- DONE: `done`=1, `stall`=0, go to IDLE. `start` is ignored in DONE because the same instruction is still in EX and leaves at this edge.
- `stall` (combinational) = (IDLE & `start` & !`flush`) | RUN | FIX.
- `busy` = state ≠ IDLE.
- Priority: reset > `flush` > `start`.
- `flush`=1 in any state: forces IDLE next cycle, `stall`=0 that cycle, and no `done` for the aborted op.
- All arithmetic is modulo 2^WIDTH (2^2W for the product). Negating 0x80…0 yields 0x80…0.

## Timing
- Reset (`rst`=0 at edge): state IDLE; `done`=0, `busy`=0, `stall`=0, `result`=0, `rd_out`=0, counter 0.
- Normal op, with `start` seen in IDLE at cycle 0:
  - Cycles 0 to WIDTH+1 (RUN is cycles 1..WIDTH, FIX is cycle WIDTH+1): `stall`=1.
  - Cycle WIDTH+2 (cycle 34 at WIDTH=32): DONE, `done`=1.
  - Total stall: WIDTH+2 cycles.
- Special-case op: `stall`=1 at cycle 0 only; `done`=1 at cycle 1.
- Back-to-back M-ops: the next `start` is accepted at cycle WIDTH+3, the first IDLE cycle after DONE.
- `result` and `rd_out` hold their value after `done` until the next FIX or special-case capture.
- Reset mid-op: IDLE on the next edge, no `done`.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD at cycle 0 -> `stall`=1 for cycles 0–33; cycle 34 `done`=1, `result`=0xFFFFFFEB, `rd_out`=rd_in; `done` is a single cycle.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD. REM −7%2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100%7 -> 2. Each has `done` at cycle 34.
- Special cases, each with `done` at cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5%0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000%0xFFFFFFFF -> 0.
- `flush` at cycle 10 of a DIV -> cycle 11 IDLE, `busy`=0, `stall`=0, no `done`. A fresh MUL 3×4 started at cycle 11 -> `done` at cycle 45 with `result`=12.
- `start` held high through DONE -> no relaunch. Second op started at cycle 35 -> `done` at 69.
- `rst`=0 at cycle 20 of a MUL -> all outputs 0 next cycle, no `done`.
